// File: rtl/vram_byte_sequencer_if.sv
// vram_byte_sequencer_if: VRAM word in, gate-array byte out, plus CAS/RAS sequencing controls
interface vram_byte_sequencer_if #(
    parameter int BYTES     = 2,
    parameter int SHIFT_MAX = 1
);
    localparam int IW = $clog2(BYTES);
    localparam int SW = $clog2(SHIFT_MAX + 1);

    logic                 cpu_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 de;
    logic                 shift_en;
    logic [SW-1:0]        shift_amt;
    logic [8*BYTES-1:0]   vram_din;
    logic [7:0]           vram_d;
    logic [IW-1:0]        byte_idx;
    logic                 byte_strobe;
    logic                 last_byte;

    modport master (
        output cpu_n, ras_n, cas_n, de, shift_en, shift_amt, vram_din,
        input  vram_d, byte_idx, byte_strobe, last_byte
    );

    modport slave (
        input  cpu_n, ras_n, cas_n, de, shift_en, shift_amt, vram_din,
        output vram_d, byte_idx, byte_strobe, last_byte
    );
endinterface

// File: rtl/vram_byte_sequencer.sv
// vram_byte_sequencer: serialises one VRAM word into per-CAS bytes with optional byte delay
module vram_byte_sequencer #(
    parameter int BYTES     = 2,
    parameter int SHIFT_MAX = 1
) (
    input logic                  clk,
    input logic                  reset,
    vram_byte_sequencer_if.slave bus
);
    localparam int IW = $clog2(BYTES);
    localparam int SW = $clog2(SHIFT_MAX + 1);
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

    logic [BYTES-1:0][7:0] din_b;
    logic [BYTES-1:0][7:0] hold;
    logic [7:0]            vram_d;
    logic [IW-1:0]         byte_idx;
    logic [IW-1:0]         idx_next;
    logic [IW-1:0]         shift;
    logic [IW-1:0]         sel;
    logic [SW-1:0]         amt;
    logic                  byte_strobe;
    logic                  cas_n_old;
    logic                  cas_rise;
    logic                  capture;
    logic                  use_hold;

    assign din_b    = bus.vram_din;
    assign cas_rise = !bus.ras_n && !cas_n_old && bus.cas_n;
    assign capture  = !bus.ras_n && !bus.cas_n;
    assign idx_next = byte_idx == LAST ? byte_idx : byte_idx + IW'(1);

    always_comb begin
        amt      = int'(bus.shift_amt) > SHIFT_MAX ? SW'(SHIFT_MAX) : bus.shift_amt;
        shift    = bus.shift_en ? IW'(amt) : '0;
        use_hold = byte_idx < shift;
        // Modulo-2^IW wrap is exact here because the held-word index is always below BYTES
        sel      = byte_idx - shift + (use_hold ? IW'(BYTES) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_d      <= '0;
            byte_idx    <= '0;
            byte_strobe <= 1'b0;
            hold        <= '0;
            cas_n_old   <= 1'b1;
        end else begin
            cas_n_old   <= bus.cas_n;
            byte_strobe <= 1'b0;
            if (!bus.cpu_n) begin
                byte_idx <= '0;
            end else begin
                if (cas_rise) begin
                    byte_idx    <= idx_next;
                    byte_strobe <= 1'b1;
                end
                if (capture) begin
                    vram_d <= use_hold ? hold[sel] : din_b[sel];
                    if (shift != '0 && byte_idx == LAST)
                        hold <= bus.de ? din_b : '0;
                end
            end
        end
    end

    assign bus.vram_d      = vram_d;
    assign bus.byte_idx    = byte_idx;
    assign bus.byte_strobe = byte_strobe;
    assign bus.last_byte   = byte_idx == LAST;
endmodule

// File: tb/tb_vram_byte_sequencer.sv
// tb_vram_byte_sequencer: vector table, corner sequences and randomized model check over three sizes
module tb_vram_byte_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, de = 1'b1, shift_en = 1'b0;
    logic [2:0]  amt = '0;
    logic [63:0] din = '0;
    int          total = 0, passed = 0;
    bit          chk = 1'b0;

    always #5 clk = ~clk;

    vram_byte_sequencer_if #(.BYTES(2), .SHIFT_MAX(1)) ifa ();
    vram_byte_sequencer_if #(.BYTES(4), .SHIFT_MAX(3)) ifb ();
    vram_byte_sequencer_if #(.BYTES(8), .SHIFT_MAX(5)) ifc ();

    assign ifa.cpu_n = cpu_n;  assign ifb.cpu_n = cpu_n;  assign ifc.cpu_n = cpu_n;
    assign ifa.ras_n = ras_n;  assign ifb.ras_n = ras_n;  assign ifc.ras_n = ras_n;
    assign ifa.cas_n = cas_n;  assign ifb.cas_n = cas_n;  assign ifc.cas_n = cas_n;
    assign ifa.de = de;        assign ifb.de = de;        assign ifc.de = de;
    assign ifa.shift_en = shift_en; assign ifb.shift_en = shift_en; assign ifc.shift_en = shift_en;
    assign ifa.shift_amt = amt[0:0]; assign ifb.shift_amt = amt[1:0]; assign ifc.shift_amt = amt;
    assign ifa.vram_din = din[15:0]; assign ifb.vram_din = din[31:0]; assign ifc.vram_din = din;

    vram_byte_sequencer #(.BYTES(2), .SHIFT_MAX(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    vram_byte_sequencer #(.BYTES(4), .SHIFT_MAX(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    vram_byte_sequencer #(.BYTES(8), .SHIFT_MAX(5)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    // Reference model: one byte slot per word position, state advanced per clock
    typedef struct {
        int          idx;
        logic [7:0]  d;
        logic [63:0] hold;
        bit          st;
        bit          cas_old;
    } ms_t;
    ms_t m [3];

    function automatic int nb_of(int j); return j == 0 ? 2 : j == 1 ? 4 : 8; endfunction
    function automatic int sm_of(int j); return j == 0 ? 1 : j == 1 ? 3 : 5; endfunction
    function automatic int sw_of(int j); return j == 0 ? 1 : j == 1 ? 2 : 3; endfunction

    function automatic ms_t step(ms_t cur, int j);
        ms_t nx = cur;
        int nb = nb_of(j);
        int req = int'(amt) % (1 << sw_of(j));
        int s = shift_en ? (req < sm_of(j) ? req : sm_of(j)) : 0;
        if (reset) begin
            nx.idx = 0; nx.d = 8'h00; nx.hold = '0; nx.st = 1'b0; nx.cas_old = 1'b1;
            return nx;
        end
        nx.cas_old = cas_n;
        nx.st = 1'b0;
        if (!cpu_n) begin
            nx.idx = 0;
            return nx;
        end
        if (!ras_n && !cas_n) begin
            nx.d = cur.idx >= s ? din[8*(cur.idx-s) +: 8] : cur.hold[8*(nb-s+cur.idx) +: 8];
            if (s > 0 && cur.idx == nb - 1) nx.hold = de ? din : '0;
        end
        if (!ras_n && !cur.cas_old && cas_n) begin
            nx.idx = cur.idx + 1 < nb ? cur.idx + 1 : nb - 1;
            nx.st = 1'b1;
        end
        return nx;
    endfunction

    always @(posedge clk) for (int j = 0; j < 3; j++) m[j] <= step(m[j], j);

    always @(negedge clk) if (chk) begin
        check("model_a_d", ifa.vram_d, m[0].d);
        check("model_a_idx", 64'(ifa.byte_idx), 64'(m[0].idx));
        check("model_a_strobe", ifa.byte_strobe, m[0].st);
        check("model_a_last", ifa.last_byte, m[0].idx == 1);
        check("model_b_d", ifb.vram_d, m[1].d);
        check("model_b_idx", 64'(ifb.byte_idx), 64'(m[1].idx));
        check("model_b_strobe", ifb.byte_strobe, m[1].st);
        check("model_b_last", ifb.last_byte, m[1].idx == 3);
        check("model_c_d", ifc.vram_d, m[2].d);
        check("model_c_idx", 64'(ifc.byte_idx), 64'(m[2].idx));
        check("model_c_strobe", ifc.byte_strobe, m[2].st);
        check("model_c_last", ifc.last_byte, m[2].idx == 7);
    end

    task automatic cyc(input logic c, input logic r, input logic s);
        @(negedge clk);
        cpu_n = c; ras_n = r; cas_n = s;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        cpu, ras, cas, de, sh;
        logic [15:0] din;
        logic [7:0]  d;
        int          idx;
        logic        st;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t v(logic c, logic r, logic s, logic e, logic h, logic [15:0] w,
                               logic [7:0] d, int i, logic st);
        vec_t x;
        x.cpu = c; x.ras = r; x.cas = s; x.de = e; x.sh = h; x.din = w; x.d = d; x.idx = i; x.st = st;
        return x;
    endfunction

    task automatic word_chk(input logic [31:0] w, input logic [31:0] exp, input string tag);
        din = {32'h0, w};
        cyc(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check($sformatf("%s_byte%0d", tag, k), ifb.vram_d, exp[8*k +: 8]);
            cyc(1'b1, 1'b0, 1'b1);
        end
        cyc(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int cnt;
        // Unshifted A55A, then delayed 2211/4433 with and without display enable
        tbl.push_back(v(1,0,1,1,0,16'hA55A,8'h00,0,0));
        tbl.push_back(v(1,0,0,1,0,16'hA55A,8'h5A,0,0));
        tbl.push_back(v(1,0,0,1,0,16'hA55A,8'h5A,0,0));
        tbl.push_back(v(1,0,1,1,0,16'hA55A,8'h5A,1,1));
        tbl.push_back(v(1,0,0,1,0,16'hA55A,8'hA5,1,0));
        tbl.push_back(v(1,0,1,1,0,16'hA55A,8'hA5,1,1));
        tbl.push_back(v(1,1,1,1,0,16'hA55A,8'hA5,1,0));
        tbl.push_back(v(0,1,1,1,1,16'h2211,8'hA5,0,0));
        tbl.push_back(v(1,0,0,1,1,16'h2211,8'h00,0,0));
        tbl.push_back(v(1,0,1,1,1,16'h2211,8'h00,1,1));
        tbl.push_back(v(1,0,0,1,1,16'h2211,8'h11,1,0));
        tbl.push_back(v(1,1,1,1,1,16'h2211,8'h11,1,0));
        tbl.push_back(v(0,1,1,1,1,16'h4433,8'h11,0,0));
        tbl.push_back(v(1,0,0,1,1,16'h4433,8'h22,0,0));
        tbl.push_back(v(1,0,1,1,1,16'h4433,8'h22,1,1));
        tbl.push_back(v(1,0,0,1,1,16'h4433,8'h33,1,0));
        tbl.push_back(v(1,1,1,1,1,16'h4433,8'h33,1,0));
        tbl.push_back(v(0,1,1,1,1,16'h2211,8'h33,0,0));
        tbl.push_back(v(1,0,0,1,1,16'h2211,8'h44,0,0));
        tbl.push_back(v(1,0,1,1,1,16'h2211,8'h44,1,1));
        tbl.push_back(v(1,0,0,0,1,16'h2211,8'h11,1,0));
        tbl.push_back(v(1,1,1,1,1,16'h2211,8'h11,1,0));
        tbl.push_back(v(0,1,1,1,1,16'h4433,8'h11,0,0));
        tbl.push_back(v(1,0,0,1,1,16'h4433,8'h00,0,0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_d", ifa.vram_d, 8'h00);
        check("reset_idx", 64'(ifa.byte_idx), 64'd0);
        check("reset_strobe", ifa.byte_strobe, 1'b0);
        check("reset_last", ifa.last_byte, 1'b0);
        chk = 1'b1;
        reset = 1'b0;
        amt = 3'd1;

        foreach (tbl[i]) begin
            de = tbl[i].de; shift_en = tbl[i].sh; din = {48'h0, tbl[i].din};
            cyc(tbl[i].cpu, tbl[i].ras, tbl[i].cas);
            check($sformatf("vec%0d_d", i), ifa.vram_d, tbl[i].d);
            check($sformatf("vec%0d_idx", i), 64'(ifa.byte_idx), 64'(tbl[i].idx));
            check($sformatf("vec%0d_strobe", i), ifa.byte_strobe, tbl[i].st);
            check($sformatf("vec%0d_last", i), ifa.last_byte, tbl[i].idx == 1);
        end

        // Reset mid-word, then CPU slot with CAS toggling must not capture
        shift_en = 1'b0; de = 1'b1; din = 64'hA55A;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check("midrst_pre_idx", 64'(ifa.byte_idx), 64'd1);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        check("midrst_d", ifa.vram_d, 8'h00);
        check("midrst_idx", 64'(ifa.byte_idx), 64'd0);
        check("midrst_strobe", ifa.byte_strobe, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        check("postrst_d", ifa.vram_d, 8'h5A);
        din = 64'h1234;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, k[0] ? 1'b0 : 1'b1);
            check($sformatf("cpu_hold%0d_d", k), ifa.vram_d, 8'h5A);
            check($sformatf("cpu_hold%0d_idx", k), 64'(ifa.byte_idx), 64'd0);
            check($sformatf("cpu_hold%0d_strobe", k), ifa.byte_strobe, 1'b0);
        end

        // Four-byte words, delay 2 then requested 7 (clamped)
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        reset = 1'b0; shift_en = 1'b1; amt = 3'd2; de = 1'b1;
        word_chk(32'h44332211, 32'h22110000, "b_w0");
        word_chk(32'h88776655, 32'h66554433, "b_w1");
        amt = 3'd7;
        word_chk(32'hCCBBAA99, 32'h99887766, "b_w2");

        // Six CAS edges inside one RAS
        cyc(1'b0, 1'b1, 1'b1);
        cnt = 0;
        repeat (6) begin
            cyc(1'b1, 1'b0, 1'b0);
            cnt += int'(ifb.byte_strobe);
            cyc(1'b1, 1'b0, 1'b1);
            cnt += int'(ifb.byte_strobe);
        end
        check("sat_idx", 64'(ifb.byte_idx), 64'd3);
        check("sat_last", ifb.last_byte, 1'b1);
        check("sat_strobes", 64'(cnt), 64'd6);
        cyc(1'b1, 1'b1, 1'b1);

        repeat (3000) begin
            reset = $urandom_range(63) == 0;
            de = $urandom_range(3) != 0;
            shift_en = $urandom_range(3) != 0;
            amt = 3'($urandom_range(7));
            din = {$urandom, $urandom};
            cyc($urandom_range(7) != 0, $urandom_range(5) == 0, 1'($urandom_range(1)));
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
